// File: rtl/csr_pkg.sv
// csr_pkg: values shared by the CSR matrix-multiply engine and its producers.
//   Matrix geometry, element/pointer/offset widths, and the FSM state encoding
//   of the dense-to-CSR encoder. No ports.
package csr_pkg;

    localparam int MAT_ROWS    = 3;
    localparam int MAT_COLS    = 3;
    localparam int MAT_LEN     = MAT_ROWS * MAT_COLS;
    localparam int DATA_SIZE   = 8;
    localparam int PTR_SIZE    = 4;   // must be able to hold MAT_LEN
    localparam int OFFSET_SIZE = 2;   // must be able to hold MAT_COLS-1

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/csr_bus_pack.sv
// csr_bus_pack: flattens CSR register arrays onto MSB-first packed buses.
//   Slot k of an N-slot bus lands in bits [(N-k)*W-1 -: W], i.e. slot 0 at the
//   top, which is the packing the CSR multiplier expects on its Mat1 inputs.
// Ports:
//   ptr         in   row-pointer array, slots 0..N_ROWS
//   offsets     in   column-offset array, slots 0..N_LEN-1
//   data        in   nonzero-value array, slots 0..N_LEN-1
//   ptr_out     out  packed row pointers
//   offsets_out out  packed column offsets
//   data_out    out  packed nonzero values
module csr_bus_pack
    import csr_pkg::*;
#(
    parameter int N_ROWS = csr_pkg::MAT_ROWS,
    parameter int N_LEN  = csr_pkg::MAT_LEN,
    parameter int DW     = csr_pkg::DATA_SIZE,
    parameter int PW     = csr_pkg::PTR_SIZE,
    parameter int OW     = csr_pkg::OFFSET_SIZE
) (
    input  logic [N_ROWS:0][PW-1:0]  ptr,
    input  logic [N_LEN-1:0][OW-1:0] offsets,
    input  logic [N_LEN-1:0][DW-1:0] data,
    output logic [(N_ROWS+1)*PW-1:0] ptr_out,
    output logic [N_LEN*OW-1:0]      offsets_out,
    output logic [N_LEN*DW-1:0]      data_out
);

    // Native packed-array order puts the highest slot at the MSB; reverse it.
    for (genvar k = 0; k <= N_ROWS; k++) begin : g_ptr
        assign ptr_out[(N_ROWS+1-k)*PW-1 -: PW] = ptr[k];
    end

    for (genvar k = 0; k < N_LEN; k++) begin : g_slot
        assign offsets_out[(N_LEN-k)*OW-1 -: OW] = offsets[k];
        assign data_out[(N_LEN-k)*DW-1 -: DW]    = data[k];
    end

endmodule

// File: rtl/dense_to_csr_encoder.sv
// dense_to_csr_encoder: compresses a row-major dense matrix into CSR form.
//   Elements arrive one per in_valid/in_ready handshake. Nonzeros are appended
//   to the data/offset slots, a row pointer is written at the end of each row,
//   and the finished matrix is held on the packed buses until csr_ready.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   in_valid     dense element valid
//   in_ready     encoder accepts an element (COLLECT)
//   in_data      dense element
//   csr_valid    buses hold a complete matrix (HOLD)
//   csr_ready    consumer takes the matrix
//   ptr_out      row pointers, ptr[0] at MSB
//   offsets_out  column offsets, slot 0 at MSB
//   data_out     nonzero values, slot 0 at MSB
//   nnz_out      nonzero count
module dense_to_csr_encoder #(
    parameter int MAT_ROWS    = csr_pkg::MAT_ROWS,
    parameter int MAT_COLS    = csr_pkg::MAT_COLS,
    parameter int MAT_LEN     = csr_pkg::MAT_LEN,
    parameter int DATA_SIZE   = csr_pkg::DATA_SIZE,
    parameter int PTR_SIZE    = csr_pkg::PTR_SIZE,
    parameter int OFFSET_SIZE = csr_pkg::OFFSET_SIZE
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_SIZE-1:0]            in_data,
    output logic                            csr_valid,
    input  logic                            csr_ready,
    output logic [(MAT_ROWS+1)*PTR_SIZE-1:0] ptr_out,
    output logic [MAT_LEN*OFFSET_SIZE-1:0]  offsets_out,
    output logic [MAT_LEN*DATA_SIZE-1:0]    data_out,
    output logic [PTR_SIZE-1:0]             nnz_out
);

    import csr_pkg::*;

    // Row counter must reach MAT_ROWS (it steps past the last row before HOLD).
    localparam int ROW_W = $clog2(MAT_ROWS + 1);

    state_t                               state_q, state_d;
    logic [ROW_W-1:0]                     row_q;
    logic [OFFSET_SIZE-1:0]               col_q;
    logic [PTR_SIZE-1:0]                  nnz_q;
    logic [MAT_ROWS:0][PTR_SIZE-1:0]      ptr_q;
    logic [MAT_LEN-1:0][OFFSET_SIZE-1:0]  off_q;
    logic [MAT_LEN-1:0][DATA_SIZE-1:0]    data_q;

    logic accept, nonzero, last_col, last_row, take;

    assign in_ready  = (state_q == COLLECT);
    assign csr_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;
    assign nonzero   = |in_data;
    assign last_col  = (col_q == OFFSET_SIZE'(MAT_COLS - 1));
    assign last_row  = (row_q == ROW_W'(MAT_ROWS - 1));
    assign take      = csr_valid && csr_ready;

    always_ff @(posedge clk) begin
        if (reset) state_q <= COLLECT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (accept && last_col && last_row) state_d = HOLD;
            HOLD:    if (csr_ready)                      state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // ptr_q[0] is never written, so it stays 0 for the whole frame.
    always_ff @(posedge clk) begin
        if (reset || take) begin
            row_q  <= '0;
            col_q  <= '0;
            nnz_q  <= '0;
            ptr_q  <= '0;
            off_q  <= '0;
            data_q <= '0;
        end else if (accept) begin
            if (nonzero) begin
                data_q[nnz_q] <= in_data;
                off_q[nnz_q]  <= col_q;
                nnz_q         <= nnz_q + 1'b1;
            end
            if (last_col) begin
                ptr_q[row_q + 1'b1] <= nnz_q + PTR_SIZE'(nonzero);
                col_q               <= '0;
                row_q               <= row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    assign nnz_out = nnz_q;

    csr_bus_pack #(
        .N_ROWS(MAT_ROWS),
        .N_LEN (MAT_LEN),
        .DW    (DATA_SIZE),
        .PW    (PTR_SIZE),
        .OW    (OFFSET_SIZE)
    ) u_pack (
        .ptr        (ptr_q),
        .offsets    (off_q),
        .data       (data_q),
        .ptr_out    (ptr_out),
        .offsets_out(offsets_out),
        .data_out   (data_out)
    );

endmodule
